// File: rtl/sincos_fp_iter.sv
// rtl/sincos_fp_iter.sv - iterative CORDIC sine (and optional cosine) for IEEE-754 single
//
// One operand per start pulse. The operand is reduced to a quadrant and a residual
// in [0, pi/2). ITER CORDIC micro-rotations follow, then the result is folded and
// renormalised to float. Completion is a one-cycle done pulse, ITER+2 cycles after
// the accepting edge.
//
// Parameters:
//   ITER     number of CORDIC micro-rotations (8..30)
//   FRAC     fraction bits of the Q2.FRAC datapath (>= ITER+4, <= 59)
// Optional feature:
//   SINX_COS_EN  when defined, adds the cos_out port and its fold/normalise path
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operand valid, accepted only in IDLE
//   x        IEEE-754 single operand, sampled on the accepting edge
//   busy     high from the edge after acceptance through NORM
//   done     one-cycle pulse when sin_out (and cos_out) are valid
//   sin_out  sin(x), held until the next done
//   invalid  qualifies done: NaN, +-inf or |x| >= 2^15
//   cos_out  cos(x), SINX_COS_EN only
module sincos_fp_iter #(
    parameter int ITER = 24,
    parameter int FRAC = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    output logic        busy,
    output logic        done,
    output logic [31:0] sin_out,
    output logic        invalid
`ifdef SINX_COS_EN
    ,
    output logic [31:0] cos_out
`endif
);

    localparam int W  = FRAC + 2;
    localparam int CW = $clog2(ITER);

    // 2/pi with 40 fraction bits, pi/2 with 32 fraction bits.
    localparam logic [39:0] TWO_OVER_PI = 40'hA2F9836E4E;
    localparam logic [32:0] PI_OVER_2   = 33'h1921FB544;
    // CORDIC gain reciprocal 1/K (32 fraction bits), realigned to FRAC.
    localparam logic [63:0] INVK_Q62    = 64'h9B74EDA8 << 30;
    localparam logic [63:0] INVK_ALIGN  = INVK_Q62 >> (62 - FRAC);

    // atan(2^-i) with 60 fraction bits; the alternating series converges
    // quickly for i >= 1, and i = 0 is pi/4.
    function automatic logic [63:0] atan_q60(input int i);
        logic [63:0] acc;
        int          sh;
        acc = 64'd0;
        if (i == 0) begin
            return 64'h0C90FDAA22168C23;
        end
        for (int k = 0; k < 32; k++) begin
            sh = 60 - i * (2 * k + 1);
            if (sh >= 0) begin
                if (k % 2 == 0) acc = acc + (64'd1 << sh) / 64'(2 * k + 1);
                else            acc = acc - (64'd1 << sh) / 64'(2 * k + 1);
            end
        end
        return acc;
    endfunction

    function automatic logic [ITER*W-1:0] build_atan();
        logic [ITER*W-1:0] t;
        logic [63:0]       a;
        t = '0;
        for (int i = 0; i < ITER; i++) begin
            a = (atan_q60(i) + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
            t[i*W +: W] = a[W-1:0];
        end
        return t;
    endfunction

    localparam logic [ITER*W-1:0] ATAN_TAB = build_atan();

    // Signed Q2.FRAC to float: leading-one detect, truncate to 23 mantissa bits.
    // Exact zero encodes as +0.
    function automatic logic [31:0] to_float(input logic signed [W-1:0] v);
        logic [W-1:0]  mag;
        logic [W+23:0] ext;
        logic [7:0]    ex;
        int            p;
        mag = v[W-1] ? -v : v;
        p   = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) p = i;
        end
        if (mag == '0) begin
            return 32'h0000_0000;
        end
        ext = {mag, 24'b0} << (W - 1 - p);
        ex  = 8'(127 + p - FRAC);
        return {v[W-1], ex, ext[W+22 -: 23]};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_ROTATE, S_NORM} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  load, do_reduce, do_rot, do_norm;

    logic [31:0]           x_r;
    logic [1:0]            q_r;
    logic                  neg_r, special_r, zero_r, tiny_r;
    logic signed [W-1:0]   xr, yr, zr;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE:   if (start) state_nxt = S_REDUCE;
            S_REDUCE: begin
                state_nxt = S_ROTATE;
                cnt_nxt   = '0;
            end
            S_ROTATE: begin
                if (cnt == CW'(ITER - 1)) begin
                    state_nxt = S_NORM;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_NORM:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- state outputs ----------------
    always_comb begin
        load      = (state == S_IDLE) && start;
        do_reduce = (state == S_REDUCE);
        do_rot    = (state == S_ROTATE);
        do_norm   = (state == S_NORM);
    end

    // ---------------- range reduction ----------------
    logic [7:0]          ex_in;
    logic [63:0]         prod, tq;
    logic [7:0]          sh;
    logic [66:0]         rprod, rsh;
    logic signed [W-1:0] z0;

    always_comb begin
        ex_in = x_r[30:23];
        prod  = {40'b0, 1'b1, x_r[22:0]} * {24'b0, TWO_OVER_PI};
        // |x|*2/pi with 34 fraction bits; shift only matters for classes
        // that reach the rotation, the rest are overridden in NORM.
        sh    = (ex_in >= 8'd115 && ex_in <= 8'd141) ? 8'd156 - ex_in : 8'd0;
        tq    = prod >> sh;
        rprod = {33'b0, tq[33:0]} * {34'b0, PI_OVER_2};
        rsh   = rprod >> (66 - FRAC);
        z0    = rsh[W-1:0];
    end

    // ---------------- micro-rotation ----------------
    logic signed [W-1:0] sx, sy, atan_i, xn, yn, zn;

    always_comb begin
        sx     = xr >>> cnt;
        sy     = yr >>> cnt;
        atan_i = $signed(ATAN_TAB[cnt*W +: W]);
        if (zr[W-1]) begin
            xn = xr + sy;
            yn = yr - sx;
            zn = zr + atan_i;
        end else begin
            xn = xr - sy;
            yn = yr + sx;
            zn = zr - atan_i;
        end
    end

    // ---------------- fold and normalise ----------------
    logic signed [W-1:0] sin_fix;
    logic [31:0]         sin_nxt;
    logic                inv_nxt;

    always_comb begin
        case (q_r)
            2'd0:    sin_fix = yr;
            2'd1:    sin_fix = xr;
            2'd2:    sin_fix = -yr;
            default: sin_fix = -xr;
        endcase
        if (neg_r) sin_fix = -sin_fix;
        inv_nxt = 1'b0;
        if (special_r) begin
            sin_nxt = 32'h7FC0_0000;
            inv_nxt = 1'b1;
        end else if (zero_r) begin
            sin_nxt = {x_r[31], 31'b0};
        end else if (tiny_r) begin
            sin_nxt = x_r;
        end else begin
            sin_nxt = to_float(sin_fix);
        end
    end

`ifdef SINX_COS_EN
    logic signed [W-1:0] cos_fix;
    logic [31:0]         cos_nxt;

    always_comb begin
        case (q_r)
            2'd0:    cos_fix = xr;
            2'd1:    cos_fix = -yr;
            2'd2:    cos_fix = -xr;
            default: cos_fix = yr;
        endcase
        if (special_r)              cos_nxt = 32'h7FC0_0000;
        else if (zero_r || tiny_r)  cos_nxt = 32'h3F80_0000;
        else                        cos_nxt = to_float(cos_fix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cos_out <= 32'h0;
        else if (do_norm) cos_out <= cos_nxt;
    end
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= 32'h0;
            q_r       <= 2'd0;
            neg_r     <= 1'b0;
            special_r <= 1'b0;
            zero_r    <= 1'b0;
            tiny_r    <= 1'b0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sin_out   <= 32'h0;
            invalid   <= 1'b0;
        end else begin
            done <= do_norm;
            if (load) x_r <= x;
            if (do_reduce) begin
                q_r       <= tq[35:34];
                neg_r     <= x_r[31];
                special_r <= (ex_in >= 8'd142);
                zero_r    <= (ex_in == 8'd0);
                tiny_r    <= (ex_in < 8'd115);
                xr        <= INVK_ALIGN[W-1:0];
                yr        <= '0;
                zr        <= z0;
                busy      <= 1'b1;
            end
            if (do_rot) begin
                xr <= xn;
                yr <= yn;
                zr <= zn;
            end
            if (do_norm) begin
                sin_out <= sin_nxt;
                invalid <= inv_nxt;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sincos_fp_iter.sv
// tb/tb_sincos_fp_iter.sv - self-checking bench for sincos_fp_iter
module tb_sincos_fp_iter;

    localparam int  ITER = 24;
    localparam int  LAT  = ITER + 2;
    localparam real TOL  = 1.0 / 1048576.0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] x;
    logic        busy;
    logic        done;
    logic [31:0] sin_out;
    logic        invalid;
`ifdef SINX_COS_EN
    logic [31:0] cos_out;
`endif

    sincos_fp_iter #(.ITER(ITER), .FRAC(30)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
        .busy    (busy),
        .done    (done),
        .sin_out (sin_out),
        .invalid (invalid)
`ifdef SINX_COS_EN
        ,
        .cos_out (cos_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // mode: 0 = real within TOL, 1 = exact bits, 2 = invalid flag only
    // cmode: 0 = no cos check, 1 = real within TOL, 2 = exact bits
    typedef struct {
        logic [31:0] xin;
        int          mode;
        logic [31:0] sbits;
        real         sval;
        logic        inv;
        int          cmode;
        logic [31:0] cbits;
        real         cval;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic [31:0] xin, int mode, logic [31:0] sbits, real sval,
                                logic inv, int cmode, logic [31:0] cbits, real cval);
        vec_t v;
        v.xin = xin; v.mode = mode; v.sbits = sbits; v.sval = sval;
        v.inv = inv; v.cmode = cmode; v.cbits = cbits; v.cval = cval;
        return v;
    endfunction

    function automatic real fp2real(logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        m = real'(f[22:0]) / 8388608.0;
        if (e == 0) m = m * (2.0 ** (-126));
        else        m = (1.0 + m) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    task automatic check_bits(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_real(string name, logic [31:0] act, real exp);
        real a, d;
        n_cmp++;
        a = fp2real(act);
        d = a - exp;
        if (d < 0.0) d = -d;
        if (!(d <= TOL)) begin
            n_bad++;
            $display("FAIL %s: got %h (%f) expected %f", name, act, a, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one operand and waits for done; lat = -1 if done never came.
    task automatic run_op(input logic [31:0] xv, output int lat, output logic [31:0] s,
                          output logic iv, output logic [31:0] c);
        start = 1'b1;
        x     = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 32'h0;
        lat   = -1;
        for (int n = 1; n <= LAT + 10; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        s  = sin_out;
        iv = invalid;
`ifdef SINX_COS_EN
        c  = cos_out;
`else
        c  = 32'h0;
`endif
    endtask

    initial begin
        int          lat;
        logic [31:0] s, c;
        logic        iv;
        int          seen;
        int          busy_late;

        tab.push_back(mk(32'hC0000000, 0, 32'h0, -0.9092974268256817, 1'b0, 1, 32'h0, -0.4161468365471424));
        tab.push_back(mk(32'h3F800000, 0, 32'h0,  0.8414709848078965, 1'b0, 1, 32'h0,  0.5403023058681398));
        tab.push_back(mk(32'hBF400000, 0, 32'h0, -0.6816387600233341, 1'b0, 1, 32'h0,  0.7316888688738209));
        tab.push_back(mk(32'h42F00000, 0, 32'h0,  0.5806111842123143, 1'b0, 0, 32'h0, 0.0));
        tab.push_back(mk(32'hC3E40000, 0, 32'h0,  0.4520526759,       1'b0, 0, 32'h0, 0.0));
        tab.push_back(mk(32'h3FC90FDB, 0, 32'h0,  1.0,                1'b0, 1, 32'h0, 0.0));
        tab.push_back(mk(32'h40C90FDB, 0, 32'h0,  0.0,                1'b0, 1, 32'h0, 1.0));
        tab.push_back(mk(32'h39800000, 0, 32'h0,  0.000244140625,     1'b0, 1, 32'h0, 1.0));
        tab.push_back(mk(32'h397FFFFF, 1, 32'h397FFFFF, 0.0, 1'b0, 2, 32'h3F800000, 0.0));
        tab.push_back(mk(32'h31000000, 1, 32'h31000000, 0.0, 1'b0, 2, 32'h3F800000, 0.0));
        tab.push_back(mk(32'h00000000, 1, 32'h00000000, 0.0, 1'b0, 2, 32'h3F800000, 0.0));
        tab.push_back(mk(32'h80000000, 1, 32'h80000000, 0.0, 1'b0, 2, 32'h3F800000, 0.0));
        tab.push_back(mk(32'h80000001, 1, 32'h80000000, 0.0, 1'b0, 2, 32'h3F800000, 0.0));
        tab.push_back(mk(32'h7F800000, 1, 32'h7FC00000, 0.0, 1'b1, 2, 32'h7FC00000, 0.0));
        tab.push_back(mk(32'hFF800000, 1, 32'h7FC00000, 0.0, 1'b1, 0, 32'h0, 0.0));
        tab.push_back(mk(32'h7FC12345, 1, 32'h7FC00000, 0.0, 1'b1, 0, 32'h0, 0.0));
        tab.push_back(mk(32'h47000000, 1, 32'h7FC00000, 0.0, 1'b1, 2, 32'h7FC00000, 0.0));
        tab.push_back(mk(32'h46FFFFFF, 2, 32'h0, 0.0, 1'b0, 0, 32'h0, 0.0));

        // reset state
        rst_n = 1'b0;
        start = 1'b0;
        x     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_bits("reset_busy",    {31'b0, busy},    32'h0);
        check_bits("reset_done",    {31'b0, done},    32'h0);
        check_bits("reset_invalid", {31'b0, invalid}, 32'h0);
        check_bits("reset_sin",     sin_out,          32'h0);
`ifdef SINX_COS_EN
        check_bits("reset_cos",     cos_out,          32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors
        foreach (tab[i]) begin
            @(negedge clk);
            run_op(tab[i].xin, lat, s, iv, c);
            check_int($sformatf("latency[%h]", tab[i].xin), lat, LAT);
            if (tab[i].mode == 0) check_real($sformatf("sin[%h]", tab[i].xin), s, tab[i].sval);
            if (tab[i].mode == 1) check_bits($sformatf("sin[%h]", tab[i].xin), s, tab[i].sbits);
            check_bits($sformatf("invalid[%h]", tab[i].xin), {31'b0, iv}, {31'b0, tab[i].inv});
`ifdef SINX_COS_EN
            if (tab[i].cmode == 1) check_real($sformatf("cos[%h]", tab[i].xin), c, tab[i].cval);
            if (tab[i].cmode == 2) check_bits($sformatf("cos[%h]", tab[i].xin), c, tab[i].cbits);
`endif
        end

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        start = 1'b1;
        x     = 32'h3F800000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_bits("busy_in_reduce", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        check_bits("busy_after_reduce", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        start = 1'b1;
        x     = 32'h40000000;
        @(posedge clk);
        #1;
        start     = 1'b0;
        x         = 32'h0;
        lat       = -1;
        busy_late = 0;
        for (int n = 4; n <= LAT + 10; n++) begin
            @(posedge clk);
            #1;
            if (n == LAT - 1) busy_late = int'(busy);
            if (done) begin
                lat = n;
                break;
            end
        end
        check_int("latency_ignored_start", lat, LAT);
        check_int("busy_before_done", busy_late, 1);
        check_bits("busy_in_done", {31'b0, busy}, 32'h0);
        check_real("sin_ignored_start", sin_out, 0.8414709848078965);

        start = 1'b1;
        x     = 32'hC0000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 32'h0;
        check_bits("done_one_cycle", {31'b0, done}, 32'h0);
        lat = -1;
        for (int n = 1; n <= LAT + 10; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check_int("latency_start_in_done", lat, LAT);
        check_real("sin_start_in_done", sin_out, -0.9092974268256817);

        // reset mid-rotation
        @(negedge clk);
        start = 1'b1;
        x     = 32'h40400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_bits("busy_before_abort", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_bits("abort_busy",    {31'b0, busy},    32'h0);
        check_bits("abort_done",    {31'b0, done},    32'h0);
        check_bits("abort_invalid", {31'b0, invalid}, 32'h0);
        check_bits("abort_sin",     sin_out,          32'h0);
`ifdef SINX_COS_EN
        check_bits("abort_cos",     cos_out,          32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int n = 0; n < LAT + 14; n++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check_int("no_done_after_abort", seen, 0);

        @(negedge clk);
        run_op(32'h3F800000, lat, s, iv, c);
        check_int("latency_after_abort", lat, LAT);
        check_real("sin_after_abort", s, 0.8414709848078965);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
